// File: rtl/fifo_stream_reader.sv
// Read-side drain engine for the synchronous FIFO: pops words, absorbs the one-cycle
// read latency in a 2-entry buffer and presents them on a valid/ready stream.
module fifo_stream_reader #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  fifo_r_en,
  output logic                  m_valid,
  output logic [DATA_WIDTH-1:0] m_data,
  input  logic                  m_ready,
  output logic [CNT_WIDTH-1:0]  word_count,
  output logic                  busy
);

  typedef enum logic [1:0] {
    OCC_0 = 2'd0,
    OCC_1 = 2'd1,
    OCC_2 = 2'd2
  } occ_t;

  occ_t                  occ, occ_next;
  logic                  pending;
  logic [DATA_WIDTH-1:0] head, tail, head_next, tail_next;
  logic                  pop, push;
  logic [2:0]            level;
  logic [2:0]            limit;

  assign m_valid = (occ != OCC_0);
  assign m_data  = head;
  assign busy    = (occ != OCC_0) || pending;
  assign pop     = m_valid && m_ready;
  assign push    = pending;

  // Words owned after this edge (buffered + in flight) must leave room for one more pop.
  assign level     = {1'b0, occ} + {2'b00, pending};
  assign limit     = 3'd1 + {2'b00, pop};
  assign fifo_r_en = !rst && !fifo_empty && (level <= limit);

  always_comb begin
    // NOTE: every variable gets its hold value first so no path through the case infers a latch.
    occ_next  = occ;
    head_next = head;
    tail_next = tail;
    case ({push, pop})
      2'b10: begin
        if (occ == OCC_0) begin
          head_next = fifo_data;
          occ_next  = OCC_1;
        end else begin
          tail_next = fifo_data;
          occ_next  = OCC_2;
        end
      end
      2'b01: begin
        head_next = tail;
        occ_next  = (occ == OCC_2) ? OCC_1 : OCC_0;
      end
      2'b11: begin
        if (occ == OCC_2) begin
          head_next = tail;
          tail_next = fifo_data;
        end else begin
          head_next = fifo_data;
        end
      end
      default: ;
    endcase
  end

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      occ        <= OCC_0;
      pending    <= 1'b0;
      // NOTE: the buffer registers are cleared too, so m_data reads 0 out of reset.
      head       <= '0;
      tail       <= '0;
      word_count <= '0;
    end else begin
      occ     <= occ_next;
      pending <= fifo_r_en;
      head    <= head_next;
      tail    <= tail_next;
      if (pop) word_count <= word_count + CNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Bench for fifo_stream_reader: behavioural FIFO model, scoreboard of written words,
// scenario tasks for reset, latency, streaming, backpressure, random traffic and wrap.
module tb_fifo_stream_reader;

  logic        clk = 1'b0;
  logic        rst;
  always #5 clk = ~clk;

  logic        fifo_empty, fifo_r_en, m_valid, m_ready, busy;
  logic [7:0]  fifo_data = 8'h00;
  logic [7:0]  m_data;
  logic [15:0] word_count;

  logic        w_fifo_empty, w_r_en, w_valid, w_ready, w_busy;
  logic [7:0]  w_data_in, w_data;
  logic [3:0]  w_count;
  assign w_data_in = 8'h3C;

  fifo_stream_reader #(.DATA_WIDTH(8), .CNT_WIDTH(16)) dut (
    .clk(clk), .rst(rst), .fifo_empty(fifo_empty), .fifo_data(fifo_data),
    .fifo_r_en(fifo_r_en), .m_valid(m_valid), .m_data(m_data), .m_ready(m_ready),
    .word_count(word_count), .busy(busy)
  );

  fifo_stream_reader #(.DATA_WIDTH(8), .CNT_WIDTH(4)) u_wrap (
    .clk(clk), .rst(rst), .fifo_empty(w_fifo_empty), .fifo_data(w_data_in),
    .fifo_r_en(w_r_en), .m_valid(w_valid), .m_data(w_data), .m_ready(w_ready),
    .word_count(w_count), .busy(w_busy)
  );

  // Behavioural FIFO: registered read, words loaded in bursts; shares rst with the reader.
  logic [7:0] fifo_q[$];
  int         fifo_cnt = 0;
  logic [7:0] load_mem[16];
  int         load_n = 0;
  logic       load_go = 1'b0;
  assign fifo_empty = (fifo_cnt == 0);

  always @(posedge clk) begin
    if (rst) fifo_q.delete();
    else if (fifo_r_en && fifo_q.size() != 0) fifo_data <= fifo_q.pop_front();
    if (load_go) for (int i = 0; i < load_n; i++) fifo_q.push_back(load_mem[i]);
    fifo_cnt <= fifo_q.size();
  end

  int         compared = 0;
  int         mismatched = 0;
  logic [7:0] exp_q[$];
  int         exp_cnt = 0;
  logic       s_ren, s_valid, s_busy, s_empty, s_pop, s_wvalid;
  logic [7:0] s_data;

  // One clock cycle: sample mid-cycle, score any handshake, then step past the edge.
  task automatic step();
    logic [7:0] exp;
    @(negedge clk);
    s_ren    = fifo_r_en;
    s_valid  = m_valid;
    s_data   = m_data;
    s_busy   = busy;
    s_empty  = fifo_empty;
    s_pop    = !rst && m_valid && m_ready;
    s_wvalid = !rst && w_valid && w_ready;
    if (s_pop) begin
      compared++;
      if (exp_q.size() == 0) begin
        mismatched++;
        $display("FAIL scoreboard: got %h, expected no word", m_data);
      end else begin
        exp = exp_q.pop_front();
        if (m_data !== exp) begin
          mismatched++;
          $display("FAIL scoreboard: got %h, expected %h", m_data, exp);
        end
      end
      exp_cnt++;
    end
    @(posedge clk);
    #1;
    load_go = 1'b0;
  endtask

  task automatic load_words(input int n, input logic [7:0] base, input bit push_exp);
    for (int i = 0; i < n; i++) begin
      load_mem[i] = 8'(base + i);
      if (push_exp) exp_q.push_back(8'(base + i));
    end
    load_n  = n;
    load_go = 1'b1;
  endtask

  task automatic reset_start();
    rst = 1'b1;
    m_ready = 1'b0;
    w_ready = 1'b0;
    w_fifo_empty = 1'b1;
    exp_q.delete();
    exp_cnt = 0;
    step();
  endtask

  task automatic reset_end();
    step();
    rst = 1'b0;
  endtask

  task automatic drain(input int max_cycles);
    int n = 0;
    while ((exp_q.size() != 0 || busy) && n < max_cycles) begin
      step();
      n++;
    end
    compared++;
    if (exp_q.size() != 0 || busy) begin
      mismatched++;
      $display("FAIL drain_timeout: %0d words left, busy=%b, expected 0 and 0", exp_q.size(), busy);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    m_ready = 1'b0;
    w_ready = 1'b0;
    w_fifo_empty = 1'b1;
    load_words(3, 8'h11, 1'b1);
    step();
    load_words(3, 8'h11, 1'b0);
    step();
    compared++;
    if ({s_ren, s_valid, s_data, word_count, s_busy} !== 27'd0 || s_empty !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_values: r_en=%b valid=%b data=%h count=%h busy=%b empty=%b, expected all 0",
               s_ren, s_valid, s_data, word_count, s_busy, s_empty);
    end
    rst = 1'b0;
    step();
    compared++;
    if (s_ren !== 1'b1) begin
      mismatched++;
      $display("FAIL first_pop_after_reset: r_en=%b, expected 1", s_ren);
    end
    m_ready = 1'b1;
    drain(20);
    compared++;
    if (word_count !== 16'd3) begin
      mismatched++;
      $display("FAIL reset_drain_count: got %0d, expected 3", word_count);
    end
  endtask

  task automatic test_single_word();
    logic [5:0] ren_log, val_log;
    reset_start();
    reset_end();
    m_ready = 1'b1;
    load_words(1, 8'hA5, 1'b1);
    for (int i = 0; i < 6; i++) begin
      step();
      ren_log[i] = s_ren;
      val_log[i] = s_valid;
    end
    compared++;
    if (ren_log !== 6'b000010 || val_log !== 6'b001000) begin
      mismatched++;
      $display("FAIL single_timing: r_en=%b valid=%b, expected 000010 001000", ren_log, val_log);
    end
    compared++;
    if (word_count !== 16'd1) begin
      mismatched++;
      $display("FAIL single_count: got %0d, expected 1", word_count);
    end
  endtask

  task automatic test_streaming();
    logic [13:0] val_log, busy_log;
    reset_start();
    m_ready = 1'b1;
    load_words(8, 8'h01, 1'b1);
    reset_end();
    for (int i = 0; i < 14; i++) begin
      step();
      val_log[i]  = s_valid;
      busy_log[i] = s_busy;
    end
    compared++;
    if (val_log !== 14'h03FC) begin
      mismatched++;
      $display("FAIL stream_valid: got %b, expected %b", val_log, 14'h03FC);
    end
    compared++;
    if (busy_log !== 14'h03FE) begin
      mismatched++;
      $display("FAIL stream_busy: got %b, expected %b", busy_log, 14'h03FE);
    end
    compared++;
    if (word_count !== 16'd8 || exp_q.size() != 0) begin
      mismatched++;
      $display("FAIL stream_count: got %0d (%0d unseen), expected 8 (0)", word_count, exp_q.size());
    end
  endtask

  task automatic test_backpressure();
    int         n = 0;
    logic [3:0] ren_log;
    reset_start();
    m_ready = 1'b1;
    load_words(8, 8'h40, 1'b1);
    reset_end();
    do begin
      step();
      n++;
    end while (!s_pop && n < 10);
    m_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      ren_log[i] = s_ren;
    end
    compared++;
    if (ren_log !== 4'b0000 || s_valid !== 1'b1 || s_data !== 8'h41 || fifo_cnt != 5) begin
      mismatched++;
      $display("FAIL stall_hold: r_en=%b valid=%b data=%h fifo=%0d, expected 0000 1 41 5",
               ren_log, s_valid, s_data, fifo_cnt);
    end
    m_ready = 1'b1;
    step();
    compared++;
    if (s_ren !== 1'b1 || s_pop !== 1'b1) begin
      mismatched++;
      $display("FAIL stall_restart: r_en=%b pop=%b, expected 1 1", s_ren, s_pop);
    end
    drain(30);
    compared++;
    if (word_count !== 16'd8) begin
      mismatched++;
      $display("FAIL stall_count: got %0d, expected 8", word_count);
    end
  endtask

  task automatic test_random();
    int written = 0;
    reset_start();
    reset_end();
    for (int i = 0; i < 400; i++) begin
      m_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 1) == 1) begin
        load_words(1, 8'($urandom), 1'b1);
        written++;
      end
      step();
      compared++;
      if (s_ren && s_empty) begin
        mismatched++;
        $display("FAIL read_while_empty: r_en=1 empty=1 at iteration %0d, expected no pop", i);
      end
    end
    m_ready = 1'b1;
    drain(60);
    compared++;
    if (word_count !== 16'(written)) begin
      mismatched++;
      $display("FAIL random_count: got %0d, expected %0d", word_count, written);
    end
  endtask

  task automatic test_reset_midstream();
    int         n = 0;
    logic [2:0] val_log;
    reset_start();
    m_ready = 1'b1;
    load_words(8, 8'h80, 1'b1);
    reset_end();
    do begin
      step();
      n++;
    end while (!s_pop && n < 10);
    m_ready = 1'b0;
    rst = 1'b1;
    exp_q.delete();
    step();
    compared++;
    if (s_ren !== 1'b0 || s_empty !== 1'b0) begin
      mismatched++;
      $display("FAIL rst_gates_pop: r_en=%b empty=%b, expected 0 0", s_ren, s_empty);
    end
    step();
    compared++;
    if (s_valid !== 1'b0 || word_count !== 16'd0 || s_busy !== 1'b0 || s_ren !== 1'b0) begin
      mismatched++;
      $display("FAIL mid_reset: valid=%b count=%0d busy=%b r_en=%b, expected 0 0 0 0",
               s_valid, word_count, s_busy, s_ren);
    end
    rst = 1'b0;
    m_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      val_log[i] = s_valid;
    end
    compared++;
    if (val_log !== 3'b000) begin
      mismatched++;
      $display("FAIL mid_reset_discard: valid=%b, expected 000", val_log);
    end
  endtask

  task automatic test_count_wrap();
    int n = 0;
    int cyc = 0;
    reset_start();
    reset_end();
    w_fifo_empty = 1'b0;
    w_ready = 1'b1;
    while (n < 17 && cyc < 60) begin
      step();
      cyc++;
      if (s_wvalid) n++;
    end
    w_ready = 1'b0;
    w_fifo_empty = 1'b1;
    compared++;
    if (n != 17 || w_count !== 4'd1) begin
      mismatched++;
      $display("FAIL count_wrap: delivered %0d count=%0d, expected 17 1", n, w_count);
    end
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_streaming();
    test_backpressure();
    test_random();
    test_reset_midstream();
    test_count_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
